// File: rtl/mcp3008_pkg.sv
// Shared constants, types and channel-pointer helpers for the MCP3008 scanner.
package mcp3008_pkg;
  localparam int ADC_W           = 10;
  localparam int NUM_CH          = 8;
  localparam int FRAME_EDGES     = 17;
  localparam int FIRST_DATA_EDGE = 8;
  localparam int CMD_BITS        = 5;

  typedef logic [ADC_W-1:0] adc_val_t;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} scan_state_t;

  // Next set mask bit strictly above cur, wrapping 7->0; a lone bit maps to itself.
  function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [2:0] cur);
    logic [2:0] nxt;
    logic [2:0] cand;
    logic       found;
    nxt   = cur;
    found = 1'b0;
    for (int i = 1; i < NUM_CH; i++) begin
      cand = cur + 3'(i);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] mask);
    logic [2:0] f;
    f = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) f = 3'(i);
    end
    return f;
  endfunction
endpackage

// File: rtl/mcp3008_avg4.sv
// Per-channel 4-sample moving average (12-bit running sum, /4); used when MCP3008_AVG4_EN is set.
// Output follows the write in the same cycle it is registered; no stall, accepts a write every clk.
module mcp3008_avg4
  import mcp3008_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [2:0]               wr_ch,
  input  adc_val_t                 wr_dat,
  output logic [NUM_CH*ADC_W-1:0]  ch_value
);
  adc_val_t    hist [NUM_CH][4];
  logic [11:0] sum  [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        for (int k = 0; k < 4; k++) hist[c][k] <= '0;
      end
    end else if (wr_en) begin
      // Oldest sample drops out of the sum as the new one enters.
      sum[wr_ch]     <= sum[wr_ch] - {2'b00, hist[wr_ch][3]} + {2'b00, wr_dat};
      hist[wr_ch][0] <= wr_dat;
      hist[wr_ch][1] <= hist[wr_ch][0];
      hist[wr_ch][2] <= hist[wr_ch][1];
      hist[wr_ch][3] <= hist[wr_ch][2];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_avg
    assign ch_value[g*ADC_W +: ADC_W] = sum[g][11:2];
  end
endmodule

// File: rtl/mcp3008_scanner.sv
// Autonomous MCP3008 SPI scanner: round-robins CH_MASK, one 35*SCLK_HALF-clk CS-low frame per sample,
// one-clk sample_valid at frame end; no backpressure. Define MCP3008_AVG4_EN for 4-sample averaged ch_value.
module mcp3008_scanner
  import mcp3008_pkg::*;
#(
  parameter int         SCLK_HALF   = 25,
  parameter int         CS_HIGH_CYC = 15,
  parameter logic [7:0] CH_MASK     = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_en,
  output logic                    AD_CLK,
  output logic                    CS,
  output logic                    DIN,
  input  logic                    DOUT,
  output logic [ADC_W-1:0]        sample_data,
  output logic [2:0]              sample_ch,
  output logic                    sample_valid,
  output logic [NUM_CH*ADC_W-1:0] ch_value,
  output logic                    busy
);
  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);
  localparam logic [7:0] HOLD_LAST = 8'(CS_HIGH_CYC - 1);
  localparam logic [4:0] LAST_EDGE = 5'(FRAME_EDGES);
  localparam logic [4:0] DATA_PREV = 5'(FIRST_DATA_EDGE - 1);
  localparam logic [2:0] FIRST_CH  = first_ch(CH_MASK);

  scan_state_t         state, state_n;
  logic [7:0]          hcnt;
  logic [4:0]          ecnt;
  logic                sclk_q;
  logic [CMD_BITS-1:0] cmd_sr;
  adc_val_t            shreg;
  logic [2:0]          ch_ptr;

  logic run, half_done, hold_done;
  logic start_frame, rise, fall, finish;

  assign run       = scan_en && (CH_MASK != 8'h00);
  assign half_done = (hcnt == HALF_LAST);
  assign hold_done = (hcnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    rise        = 1'b0;
    fall        = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_n     = SETUP;
          start_frame = 1'b1;
        end
      end
      SETUP: begin
        if (half_done) begin
          state_n = SHIFT;
          rise    = 1'b1;
        end
      end
      SHIFT: begin
        if (half_done) begin
          if (sclk_q)                fall = 1'b1;
          else if (ecnt == LAST_EDGE) begin
            state_n = HOLD;
            finish  = 1'b1;
          end else                   rise = 1'b1;
        end
      end
      HOLD: begin
        if (hold_done) begin
          if (run) begin
            state_n     = SETUP;
            start_frame = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt         <= '0;
      ecnt         <= '0;
      sclk_q       <= 1'b0;
      cmd_sr       <= '0;
      shreg        <= '0;
      ch_ptr       <= FIRST_CH;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
    end else begin
      sample_valid <= finish;
      if (state == IDLE || state_n != state || rise || fall) hcnt <= '0;
      else                                                    hcnt <= hcnt + 8'd1;

      // Command shifts out MSB first; a new bit is presented on every falling edge.
      if (start_frame) cmd_sr <= {2'b11, ch_ptr};
      else if (fall)   cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};

      if (start_frame) ecnt <= '0;
      else if (rise)   ecnt <= ecnt + 5'd1;

      if (rise)      sclk_q <= 1'b1;
      else if (fall) sclk_q <= 1'b0;

      if (rise && ecnt >= DATA_PREV) shreg <= {shreg[ADC_W-2:0], DOUT};

      if (finish) begin
        sample_data <= shreg;
        sample_ch   <= ch_ptr;
        ch_ptr      <= next_ch(CH_MASK, ch_ptr);
      end
    end
  end

  assign CS     = !(state == SETUP || state == SHIFT);
  assign busy   = !CS;
  assign AD_CLK = sclk_q;
  assign DIN    = cmd_sr[CMD_BITS-1];

`ifdef MCP3008_AVG4_EN
  mcp3008_avg4 u_avg4 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (finish),
    .wr_ch    (ch_ptr),
    .wr_dat   (shreg),
    .ch_value (ch_value)
  );
`else
  adc_val_t raw_q [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) raw_q[c] <= '0;
    end else if (finish) begin
      raw_q[ch_ptr] <= shreg;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_raw
    assign ch_value[g*ADC_W +: ADC_W] = raw_q[g];
  end
`endif
endmodule

// File: tb/tb_mcp3008_scanner.sv
// Scoreboard bench for mcp3008_scanner: behavioural MCP3008 model, expected-sample queue, frame timing monitor.
`timescale 1ns/1ps
module tb_mcp3008_scanner;
  localparam int HALF   = 25;
  localparam int HOLDC  = 15;
  localparam int CS_LOW = 35 * HALF;
  localparam int PERIOD = CS_LOW + HOLDC;

  typedef struct packed {logic [2:0] ch; logic [9:0] dat;} exp_t;

  logic        clk = 1'b0, rst = 1'b1, scan_en = 1'b0, dout = 1'b0;
  logic        ad_clk, cs, din, sample_valid, busy;
  logic [9:0]  sample_data;
  logic [2:0]  sample_ch;
  logic [79:0] ch_value;

  logic        scan0 = 1'b1;
  logic        ad_clk0, cs0, din0, vld0, busy0;
  logic [9:0]  sd0;
  logic [2:0]  sc0;
  logic [79:0] chv0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mcp3008_scanner #(.SCLK_HALF(HALF), .CS_HIGH_CYC(HOLDC), .CH_MASK(8'h21)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .AD_CLK(ad_clk), .CS(cs), .DIN(din), .DOUT(dout),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .ch_value(ch_value), .busy(busy)
  );

  mcp3008_scanner #(.CH_MASK(8'h00)) dut0 (
    .clk(clk), .rst(rst), .scan_en(scan0), .AD_CLK(ad_clk0), .CS(cs0), .DIN(din0), .DOUT(1'b1),
    .sample_data(sd0), .sample_ch(sc0), .sample_valid(vld0), .ch_value(chv0), .busy(busy0)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] adc_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 10'h155;
      3'd5:    return 10'h3FF;
      default: return 10'h2AA;
    endcase
  endfunction

  exp_t exp_q[$];

  // ADC model plus per-frame timing checks
  int         rise_cnt = 0, low_cnt = 0;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1, aborted = 1'b0;
  logic [4:0] cmd = '0;
  logic [9:0] val = '0;

  initial forever begin
    @(negedge clk);
    if (rst) aborted = 1'b1;
    if (cs) begin
      if (!prev_cs && !aborted) begin
        check("cs_low_clks", 80'(low_cnt), 80'(CS_LOW));
        check("sclk_rises", 80'(rise_cnt), 80'(17));
      end
      if (!rst) aborted = 1'b0;
      rise_cnt = 0;
      low_cnt  = 0;
      dout     = 1'b0;
    end else begin
      low_cnt++;
      if (ad_clk && !prev_sclk) begin
        rise_cnt++;
        if (rise_cnt <= 5) cmd = {cmd[3:0], din};
        if (rise_cnt == 5) begin
          val = adc_val(cmd[2:0]);
          check("start_sgl", 80'(cmd[4:3]), 80'(2'b11));
          if (exp_q.size() > 0) check("din_cmd", 80'(cmd), 80'({2'b11, exp_q[0].ch}));
        end
      end else if (!ad_clk && prev_sclk) begin
        // Drive junk ahead of the sample/null edges 6 and 7
        if (rise_cnt == 5 || rise_cnt == 6)       dout = 1'b1;
        else if (rise_cnt >= 7 && rise_cnt <= 16) dout = val[16 - rise_cnt];
        else                                      dout = 1'b0;
      end
    end
    prev_sclk = ad_clk;
    prev_cs   = cs;
  end

  // Scoreboard monitor
  logic [79:0] exp_chv = '0;
  int          hist [8][4];
  longint      cyc = 0, last_vld = -1;
  int          pops = 0;
  logic        prev_vld = 1'b0;

  always @(posedge clk) cyc++;

  initial forever begin
    exp_t e;
    int   s;
    @(negedge clk);
    if (prev_vld) check("valid_width", 80'(sample_valid), 80'(1'b0));
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got ch %0d data %0h expected none", sample_ch, sample_data);
      end else begin
        e = exp_q.pop_front();
        pops++;
`ifdef MCP3008_AVG4_EN
        for (int k = 3; k > 0; k--) hist[e.ch][k] = hist[e.ch][k-1];
        hist[e.ch][0] = int'(e.dat);
        s = 0;
        for (int k = 0; k < 4; k++) s += hist[e.ch][k];
        exp_chv[int'(e.ch)*10 +: 10] = 10'(s / 4);
`else
        s = 0;
        exp_chv[int'(e.ch)*10 +: 10] = e.dat;
`endif
        check("sample_ch", 80'(sample_ch), 80'(e.ch));
        check("sample_data", 80'(sample_data), 80'(e.dat));
        check("ch_value", ch_value, exp_chv);
        check("busy_at_valid", 80'(busy), 80'(1'b0));
        if (last_vld >= 0) check("valid_period", 80'(cyc - last_vld), 80'(PERIOD));
        last_vld = cyc;
      end
    end
    prev_vld = sample_valid;
  end

  task automatic push(input logic [2:0] c, input logic [9:0] d);
    exp_q.push_back({c, d});
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i;
    i = 0;
    while (pops < n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check("pops_reached", 80'(pops), 80'(n));
  endtask

  task automatic wait_rise(input int r, input int budget);
    int i;
    i = 0;
    while (rise_cnt != r && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check("rise_reached", 80'(rise_cnt), 80'(r));
  endtask

  // Empty mask: must never leave IDLE
  logic bad0 = 1'b0, done0 = 1'b0;
  initial begin
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!cs0 || ad_clk0 || din0 || vld0 || busy0) bad0 = 1'b1;
    end
    check("mask0_idle", 80'(bad0), 80'(1'b0));
    check("mask0_regs", {70'd0, sd0} | 80'(sc0) | chv0, 80'd0);
    done0 = 1'b1;
  end

`ifdef MCP3008_AVG4_EN
  logic        scan3 = 1'b0, dout3 = 1'b0, done3 = 1'b0, prev3 = 1'b0;
  logic        ad_clk3, cs3, din3, vld3, busy3;
  logic [9:0]  sd3;
  logic [9:0]  val3 = 10'h100;
  logic [2:0]  sc3;
  logic [79:0] chv3;
  logic [9:0]  q3[$];
  int          rise3 = 0;

  mcp3008_scanner #(.SCLK_HALF(2), .CS_HIGH_CYC(1), .CH_MASK(8'h08)) dut3 (
    .clk(clk), .rst(rst), .scan_en(scan3), .AD_CLK(ad_clk3), .CS(cs3), .DIN(din3), .DOUT(dout3),
    .sample_data(sd3), .sample_ch(sc3), .sample_valid(vld3), .ch_value(chv3), .busy(busy3)
  );

  initial forever begin
    @(negedge clk);
    if (cs3) begin
      rise3 = 0;
      dout3 = 1'b0;
    end else if (ad_clk3 && !prev3) begin
      rise3++;
    end else if (!ad_clk3 && prev3) begin
      dout3 = (rise3 >= 7 && rise3 <= 16) ? val3[16 - rise3] : 1'b0;
    end
    prev3 = ad_clk3;
  end

  initial forever begin
    logic [9:0] e3;
    @(negedge clk);
    if (vld3 && q3.size() > 0) begin
      e3 = q3.pop_front();
      check("avg_sample_raw", 80'(sd3), 80'(10'h100));
      check("avg_ch", 80'({busy3, sc3}), 80'(4'd3));
      check("avg_ch_value3", 80'(chv3[39:30]), 80'(e3));
    end
  end

  initial begin
    int i;
    q3.push_back(10'h040);
    q3.push_back(10'h080);
    q3.push_back(10'h0C0);
    q3.push_back(10'h100);
    @(negedge rst);
    @(negedge clk);
    scan3 = 1'b1;
    i = 0;
    while (q3.size() > 0 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    scan3 = 1'b0;
    check("avg_all_seen", 80'(q3.size()), 80'd0);
    done3 = 1'b1;
  end
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  logic stray = 1'b0;
  initial begin
    int i;
    repeat (3) @(negedge clk);
    check("rst_cs", 80'(cs), 80'(1'b1));
    check("rst_sclk", 80'(ad_clk), 80'(1'b0));
    check("rst_din", 80'(din), 80'(1'b0));
    check("rst_busy_valid", 80'({busy, sample_valid}), 80'd0);
    check("rst_sample", 80'({sample_ch, sample_data}), 80'd0);
    check("rst_ch_value", ch_value, 80'd0);
    rst = 1'b0;

    push(3'd0, 10'h155);
    push(3'd5, 10'h3FF);
    push(3'd0, 10'h155);
    push(3'd5, 10'h3FF);
    push(3'd0, 10'h155);
    @(negedge clk);
    scan_en = 1'b1;
    wait_pops(4, 4 * PERIOD + 200);
    wait_rise(3, PERIOD);
    scan_en = 1'b0;
    wait_pops(5, PERIOD + 100);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!cs || busy || ad_clk) stray = 1'b1;
    end
    check("idle_after_stop", 80'(stray), 80'(1'b0));

    // Restarted frame is on ch5; kill it at rising edge 12
    last_vld = -1;
    scan_en  = 1'b1;
    wait_rise(12, PERIOD);
    rst = 1'b1;
    #1;
    check("midrst_cs", 80'(cs), 80'(1'b1));
    check("midrst_sclk", 80'(ad_clk), 80'(1'b0));
    check("midrst_ch_value", ch_value, 80'd0);
    check("midrst_busy", 80'({busy, sample_valid}), 80'd0);
    exp_chv  = '0;
    last_vld = -1;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++) hist[c][k] = 0;
    repeat (3) @(negedge clk);
    push(3'd0, 10'h155);
    rst = 1'b0;
    wait_pops(6, PERIOD + 100);
    scan_en = 1'b0;

    i = 0;
    while (!done0 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check("mask0_done", 80'(done0), 80'(1'b1));
`ifdef MCP3008_AVG4_EN
    check("avg_done", 80'(done3), 80'(1'b1));
`endif
    repeat (PERIOD) @(negedge clk);
    check("queue_drained", 80'(exp_q.size()), 80'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
